// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and write-back request type for the write-back arbiter.
//   XLEN     - default write-back data width
//   REG_AW   - register address width (x0..x31)
//   wb_req_t - one write-back request {rd, data}
package wb_arbiter_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO holding long-latency write-back results.
//   i_clk, i_rst_n - clock, asynchronous active-low reset (clears pointers and count)
//   i_push, i_din  - enqueue request and entry (ignored while full)
//   i_pop, o_dout  - dequeue request (ignored while empty) and current head entry
//   o_full, o_empty, o_count - occupancy status, all from the registered count
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter type T     = wb_req_t,
   parameter int  DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  T              i_din,
   input  logic          i_pop,
   output T              o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

   always_ff @(posedge i_clk)
      if (w_push) r_mem[r_wr_ptr] <= i_din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges in-order pipeline retirement and buffered long-latency results onto
// a single registered register-file write port, with a pending-register scoreboard.
//   i_clk, i_rst_n                           - clock, asynchronous active-low reset
//   i_pipe_valid/i_pipe_rd/i_pipe_data       - pipeline retire (highest priority, no backpressure)
//   i_ll_valid/i_ll_rd/i_ll_data, o_ll_ready - long-latency result handshake into the FIFO
//   i_iss_valid/i_iss_rd                     - long-latency issue, marks rd pending
//   o_pend_vec                               - registered pending scoreboard
//   o_stall_req                              - one-cycle request to idle the pipeline for a drain
//   o_wb_we/o_wb_rd/o_wb_data                - registered register-file write port
//   i_rs1_addr/i_rs2_addr, o_fwdN_hit/data   - bypass of the write port to decode
// Build option: define WB_ARBITER_BYPASS_EN to enable the bypass; otherwise fwd outputs are 0.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN       = wb_arbiter_pkg::XLEN,
   parameter int LL_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pipe_valid,
   input  logic [REG_AW-1:0] i_pipe_rd,
   input  logic [XLEN-1:0]   i_pipe_data,
   input  logic              i_ll_valid,
   input  logic [REG_AW-1:0] i_ll_rd,
   input  logic [XLEN-1:0]   i_ll_data,
   output logic              o_ll_ready,
   input  logic              i_iss_valid,
   input  logic [REG_AW-1:0] i_iss_rd,
   output logic [31:0]       o_pend_vec,
   output logic              o_stall_req,
   output logic              o_wb_we,
   output logic [REG_AW-1:0] o_wb_rd,
   output logic [XLEN-1:0]   o_wb_data,
   input  logic [REG_AW-1:0] i_rs1_addr,
   input  logic [REG_AW-1:0] i_rs2_addr,
   output logic              o_fwd1_hit,
   output logic [XLEN-1:0]   o_fwd1_data,
   output logic              o_fwd2_hit,
   output logic [XLEN-1:0]   o_fwd2_data
);
   localparam int CW = $clog2(LL_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } req_t;

   req_t              w_ll_req;
   req_t              w_head;
   logic              w_empty;
   logic              w_full;
   logic [CW-1:0]     w_count;
   logic              w_pipe_win;
   logic              w_pop;
   logic              w_push;
   logic [SW-1:0]     w_starve_nxt;
   logic [31:0]       w_pend_nxt;
   logic              w_unused;
   logic [SW-1:0]     r_starve;
   logic              r_stall;
   logic [31:0]       r_pend;
   logic              r_wb_we;
   logic [REG_AW-1:0] r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;

   assign w_ll_req   = '{rd: i_ll_rd, data: i_ll_data};
   // Writes to x0 are dropped at the source, so neither path can ever write x0.
   assign w_pipe_win = i_pipe_valid && i_pipe_rd != '0;
   assign w_pop      = !w_empty && !w_pipe_win;
   assign w_push     = i_ll_valid && o_ll_ready && i_ll_rd != '0;
   assign o_ll_ready = w_count < CW'(LL_DEPTH);

   wb_fifo #(.T(req_t), .DEPTH(LL_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_din   (w_ll_req),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Starvation counts only cycles where a queued result loses to the pipe; the stall
   // cycle itself always restarts it so the request lasts exactly one cycle.
   // A same-cycle issue of the popped register wins over the clear: the new op is still pending.
   always_comb begin
      w_starve_nxt = (!w_empty && w_pipe_win && !r_stall) ? r_starve + SW'(1) : '0;
      w_pend_nxt   = r_pend;
      if (w_pop) w_pend_nxt[w_head.rd] = 1'b0;
      if (i_iss_valid) w_pend_nxt[i_iss_rd] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_starve  <= '0;
         r_stall   <= 1'b0;
         r_pend    <= '0;
         r_wb_we   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         r_starve <= w_starve_nxt;
         r_stall  <= w_starve_nxt == SW'(STARVE_MAX);
         r_pend   <= w_pend_nxt;
         r_wb_we  <= w_pipe_win || w_pop;
         if (w_pipe_win || w_pop) begin
            r_wb_rd   <= w_pipe_win ? i_pipe_rd : w_head.rd;
            r_wb_data <= w_pipe_win ? i_pipe_data : w_head.data;
         end
      end

   assign o_stall_req = r_stall;
   assign o_pend_vec  = r_pend;
   assign o_wb_we     = r_wb_we;
   assign o_wb_rd     = r_wb_rd;
   assign o_wb_data   = r_wb_data;

`ifdef WB_ARBITER_BYPASS_EN
   assign o_fwd1_hit  = r_wb_we && r_wb_rd == i_rs1_addr && i_rs1_addr != '0;
   assign o_fwd1_data = r_wb_data;
   assign o_fwd2_hit  = r_wb_we && r_wb_rd == i_rs2_addr && i_rs2_addr != '0;
   assign o_fwd2_data = r_wb_data;
   assign w_unused    = w_full;
`else
   assign o_fwd1_hit  = 1'b0;
   assign o_fwd1_data = '0;
   assign o_fwd2_hit  = 1'b0;
   assign o_fwd2_data = '0;
   assign w_unused    = ^{w_full, i_rs1_addr, i_rs2_addr};
`endif

   // The pipeline must idle while a drain is requested; the pipe still wins if it does not.
   a_no_pipe_in_stall: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(r_stall && i_pipe_valid));
   a_no_x0_write: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(r_wb_we && r_wb_rd == '0));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, hand sequences and a randomized run against a queue-based model.
module tb_wb_arbiter;
   localparam int XLEN = 32, DEPTH = 2, SMAX = 4;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            pv, lv, iv, ll_ready, stall, we, f1h, f2h;
   logic [4:0]      prd, lrd, ird, rs1, rs2, wrd;
   logic [XLEN-1:0] pd, ld, wdata, f1d, f2d;
   logic [31:0]     pend;
   int              n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .LL_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pipe_valid(pv), .i_pipe_rd(prd), .i_pipe_data(pd),
      .i_ll_valid(lv), .i_ll_rd(lrd), .i_ll_data(ld), .o_ll_ready(ll_ready),
      .i_iss_valid(iv), .i_iss_rd(ird), .o_pend_vec(pend), .o_stall_req(stall),
      .o_wb_we(we), .o_wb_rd(wrd), .o_wb_data(wdata),
      .i_rs1_addr(rs1), .i_rs2_addr(rs2),
      .o_fwd1_hit(f1h), .o_fwd1_data(f1d), .o_fwd2_hit(f2h), .o_fwd2_data(f2d)
   );

   typedef struct {
      int pv; int prd; logic [31:0] pd;
      int lv; int lrd; logic [31:0] ld;
      int iv; int ird;
      int we; int rd; logic [31:0] data;
      int stall; int ready; logic [31:0] pend;
   } vec_t;
   vec_t tbl [15];

   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
   ent_t        q[$];
   int          m_cnt;
   bit          m_stall, m_we;
   logic [31:0] m_pend;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pv = 0; prd = 0; pd = 0; lv = 0; lrd = 0; ld = 0; iv = 0; ird = 0;
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = 0; m_stall = 0; m_pend = 0; m_we = 0; m_rd = 0; m_data = 0;
   endtask

   // Applies the arbitration rules to the inputs present before the coming edge.
   task automatic model_step();
      int   n = q.size();
      bit   win = pv && prd != 0;
      bit   pop = n > 0 && !win;
      bit   acc = lv && n < DEPTH;
      ent_t h;
      m_cnt   = (n > 0 && win && !m_stall) ? m_cnt + 1 : 0;
      m_stall = m_cnt == SMAX;
      m_we    = win || pop;
      if (pop) begin
         h = q.pop_front();
         m_pend[h.rd] = 1'b0;
      end
      if (win) begin m_rd = prd; m_data = pd; end
      else if (pop) begin m_rd = h.rd; m_data = h.data; end
      if (iv) m_pend[ird] = 1'b1;
      m_pend[0] = 1'b0;
      if (acc && lrd != 0) q.push_back('{lrd, ld});
   endtask

   task automatic model_check();
      bit e1, e2;
`ifdef WB_ARBITER_BYPASS_EN
      e1 = m_we && m_rd == rs1 && rs1 != 0;
      e2 = m_we && m_rd == rs2 && rs2 != 0;
`else
      e1 = 0;
      e2 = 0;
      chk("fwd1_data_tied", f1d, 0);
      chk("fwd2_data_tied", f2d, 0);
`endif
      chk("rnd_wb_we", we, m_we);
      if (m_we) begin
         chk("rnd_wb_rd", wrd, m_rd);
         chk("rnd_wb_data", wdata, m_data);
      end
      chk("rnd_pend_vec", pend, m_pend);
      chk("rnd_stall_req", stall, m_stall);
      chk("rnd_ll_ready", ll_ready, q.size() < DEPTH);
      chk("rnd_fwd1_hit", f1h, e1);
      chk("rnd_fwd2_hit", f2h, e2);
      if (e1) chk("rnd_fwd1_data", f1d, m_data);
      if (e2) chk("rnd_fwd2_data", f2d, m_data);
   endtask

   initial begin
      //        pv prd pd        lv lrd ld       iv ird  we rd data     st rdy pend
      tbl = '{
         '{1, 5, 'h1234,  0, 0,  0,      0, 0,   1, 5,  'h1234, 0, 1, 'h0},
         '{0, 0, 0,       0, 0,  0,      0, 0,   0, 0,  0,      0, 1, 'h0},
         '{0, 0, 0,       0, 0,  0,      1, 7,   0, 0,  0,      0, 1, 'h80},
         '{0, 0, 0,       1, 7,  'hDEAD, 0, 0,   0, 0,  0,      0, 1, 'h80},
         '{0, 0, 0,       0, 0,  0,      0, 0,   1, 7,  'hDEAD, 0, 1, 'h0},
         '{1, 1, 1,       1, 9,  'hA,    1, 9,   1, 1,  1,      0, 1, 'h200},
         '{1, 2, 2,       1, 10, 'hB,    1, 10,  1, 2,  2,      0, 0, 'h600},
         '{1, 3, 3,       1, 11, 'hC,    1, 11,  1, 3,  3,      0, 0, 'hE00},
         '{1, 4, 4,       1, 11, 'hC,    0, 0,   1, 4,  4,      0, 0, 'hE00},
         '{1, 5, 5,       1, 11, 'hC,    0, 0,   1, 5,  5,      1, 0, 'hE00},
         '{0, 0, 0,       1, 11, 'hC,    0, 0,   1, 9,  'hA,    0, 1, 'hC00},
         '{1, 6, 6,       1, 11, 'hC,    0, 0,   1, 6,  6,      0, 0, 'hC00},
         '{1, 0, 'hFFFF,  0, 0,  0,      0, 0,   1, 10, 'hB,    0, 1, 'h800},
         '{0, 0, 0,       0, 0,  0,      1, 11,  1, 11, 'hC,    0, 1, 'h800},
         '{0, 0, 0,       0, 0,  0,      1, 0,   0, 0,  0,      0, 1, 'h800}
      };
      idle();
      rs1 = 0; rs2 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_we", we, 0);
      chk("rst_wb_rd", wrd, 0);
      chk("rst_wb_data", wdata, 0);
      chk("rst_pend", pend, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ll_ready", ll_ready, 1);
      rst_n = 1;

      foreach (tbl[i]) begin
         pv = tbl[i].pv[0]; prd = tbl[i].prd[4:0]; pd = tbl[i].pd;
         lv = tbl[i].lv[0]; lrd = tbl[i].lrd[4:0]; ld = tbl[i].ld;
         iv = tbl[i].iv[0]; ird = tbl[i].ird[4:0];
         step();
         chk($sformatf("vec%0d_wb_we", i), we, tbl[i].we);
         if (tbl[i].we != 0) begin
            chk($sformatf("vec%0d_wb_rd", i), wrd, tbl[i].rd);
            chk($sformatf("vec%0d_wb_data", i), wdata, tbl[i].data);
         end
         chk($sformatf("vec%0d_stall", i), stall, tbl[i].stall);
         chk($sformatf("vec%0d_ll_ready", i), ll_ready, tbl[i].ready);
         chk($sformatf("vec%0d_pend", i), pend, tbl[i].pend);
      end

      // Bypass of a freshly written x3.
      idle();
      pv = 1; prd = 3; pd = 'h33;
      step();
      pv = 0; prd = 0; rs1 = 3; rs2 = 0;
      #1;
`ifdef WB_ARBITER_BYPASS_EN
      chk("byp_fwd1_hit", f1h, 1);
      chk("byp_fwd1_data", f1d, 'h33);
      chk("byp_fwd2_hit", f2h, 0);
`else
      chk("byp_fwd1_hit", f1h, 0);
      chk("byp_fwd1_data", f1d, 0);
      chk("byp_fwd2_hit", f2h, 0);
      chk("byp_fwd2_data", f2d, 0);
`endif

      // Reset with two entries queued: contents must be discarded.
      pv = 1; prd = 1; pd = 1; lv = 1; lrd = 12; ld = 'h12; iv = 1; ird = 12;
      step();
      pv = 1; prd = 2; pd = 2; lv = 1; lrd = 13; ld = 'h13; iv = 1; ird = 13;
      step();
      chk("mid_full_ready", ll_ready, 0);
      idle();
      #2 rst_n = 0;
      #1;
      chk("mid_rst_wb_we", we, 0);
      chk("mid_rst_wb_rd", wrd, 0);
      chk("mid_rst_wb_data", wdata, 0);
      chk("mid_rst_pend", pend, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_ll_ready", ll_ready, 1);
      chk("mid_rst_fwd1", f1h, 0);
      @(negedge clk);
      rst_n = 1;
      step();
      chk("post_rst_ll_ready", ll_ready, 1);
      chk("post_rst_wb_we0", we, 0);
      step();
      chk("post_rst_wb_we1", we, 0);

      // Randomized run against the reference model, with one asynchronous reset midway.
      model_reset();
      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            rst_n = 0;
            model_reset();
            #2;
            chk("rnd_rst_ll_ready", ll_ready, 1);
            chk("rnd_rst_wb_we", we, 0);
            @(negedge clk);
            rst_n = 1;
         end
         pv  = !m_stall && $urandom_range(0, 99) < 60;
         prd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         pd  = $urandom;
         lv  = $urandom_range(0, 1) == 1;
         lrd = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ld  = $urandom;
         iv  = $urandom_range(0, 2) == 0;
         ird = 5'($urandom_range(0, 31));
         rs1 = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 31)) : prd;
         rs2 = $urandom_range(0, 3) == 0 ? 5'd0 : ($urandom_range(0, 1) == 1 ? lrd : prd);
         model_step();
         step();
         model_check();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
